// File: rtl/pea_op_sched.sv
// pea_op_sched: sequences one F/G layer operation of the SC decoder over the
// shared P-lane PE array. Issues LLR reads one beat per cycle, then replays
// the beat address, opcode and lane mask RD_LAT cycles later as write-back.
module pea_op_sched #(
  parameter int LOG_N   = 10,
  parameter int LOG_P   = 4,
  parameter int RD_LAT  = 1,
  parameter int STAGE_W = 4,
  parameter int ADDR_W  = ((LOG_N - 1 - LOG_P) > 1) ? (LOG_N - 1 - LOG_P) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_op,
  input  logic [STAGE_W-1:0]   cmd_stage,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic                 pe_op,
  output logic [(1<<LOG_P)-1:0] pe_mask,
  output logic                 done,
  output logic                 err
);

  localparam int P = 1 << LOG_P;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Active-lane mask: low min(P, 2^(s-1)) bits set.
  function automatic logic [P-1:0] calc_mask(input logic [STAGE_W-1:0] s);
    logic [P-1:0] m;
    int lanes;
    m = '0;
    if (s != '0) begin
      if (int'(s) - 1 >= LOG_P) begin
        m = '1;
      end else begin
        lanes = 1 << (int'(s) - 1);
        for (int i = 0; i < P; i++) begin
          if (i < lanes) m[i] = 1'b1;
        end
      end
    end
    return m;
  endfunction

  // Index of the final beat, B-1, where B = 2^(s-1-LOG_P) or 1.
  function automatic logic [ADDR_W-1:0] calc_last(input logic [STAGE_W-1:0] s);
    int b;
    b = 0;
    if (s != '0 && int'(s) <= LOG_N && int'(s) - 1 >= LOG_P)
      b = (1 << (int'(s) - 1 - LOG_P)) - 1;
    return b[ADDR_W-1:0];
  endfunction

  logic [1:0]        state;
  logic [ADDR_W-1:0] beat;
  logic [ADDR_W-1:0] last_beat;
  logic              op_q;
  logic [P-1:0]      mask_q;
  logic              err_q;
  logic              cmd_legal;
  logic              pend;

  // Read-side delay line; index RD_LAT-1 is the write-back stage.
  logic              vld_p  [RD_LAT];
  logic [ADDR_W-1:0] addr_p [RD_LAT];
  logic              op_p   [RD_LAT];
  logic [P-1:0]      mask_p [RD_LAT];

  assign cmd_legal = (cmd_stage != '0) && (int'(cmd_stage) <= LOG_N);

  assign cmd_ready = (state == IDLE);
  assign rd_en     = (state == ISSUE);
  assign rd_addr   = rd_en ? beat : '0;
  assign done      = (state == DONE);
  assign err       = done & err_q;

  assign wr_en   = vld_p[RD_LAT-1];
  assign wr_addr = addr_p[RD_LAT-1];
  assign pe_op   = op_p[RD_LAT-1];
  assign pe_mask = mask_p[RD_LAT-1];

  // Beats still in flight ahead of the write-back stage.
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) pend = pend | vld_p[i];
  end

  // Command capture, beat counting and state sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= '0;
      last_beat <= '0;
      op_q      <= 1'b0;
      mask_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            mask_q    <= calc_mask(cmd_stage);
            last_beat <= calc_last(cmd_stage);
            beat      <= '0;
            err_q     <= ~cmd_legal;
            state     <= cmd_legal ? ISSUE : DONE;
          end
        end
        ISSUE: begin
          if (beat == last_beat) state <= DRAIN;
          else                   beat  <= beat + 1'b1;
        end
        DRAIN: begin
          if (!pend) state <= DONE;
        end
        default: begin
          beat  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Stage p0 takes the read strobe; later stages shift toward write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_p[i]  <= 1'b0;
        addr_p[i] <= '0;
        op_p[i]   <= 1'b0;
        mask_p[i] <= '0;
      end
    end else begin
      vld_p[0]  <= rd_en;
      addr_p[0] <= rd_addr;
      op_p[0]   <= rd_en & op_q;
      mask_p[0] <= rd_en ? mask_q : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i]  <= vld_p[i-1];
        addr_p[i] <= addr_p[i-1];
        op_p[i]   <= op_p[i-1];
        mask_p[i] <= mask_p[i-1];
      end
    end
  end

endmodule
